iomem_initiator: RTL and testbench

- Bus master for the PicoSoC iomem interface; it drives the same valid/ready/addr/wdata/wstrb/rdata signals that the CPU drives toward GPIO (0x03xxxxxx) and configurable logic (0x04xxxxxx).
- Accepts word-burst commands on a valid/ready command port, issues one iomem transaction per beat with incrementing address, and returns one response per beat.
- Gives a non-CPU agent (debug bridge, DMA) access to peripherals, with a ready-timeout so a dead responder cannot hang it.

---
 rtl/iomem_pkg.sv | 25 ++
 rtl/iomem_watchdog.sv | 44 ++++
 rtl/iomem_initiator.sv | 221 ++++++++++++++++++++++
 tb/tb_iomem_initiator.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem bus initiator: bus widths, FSM encoding,
// error fill pattern and PicoSoC peripheral region bases.
package iomem_pkg;

   localparam int IOMEM_AW = 32;
   localparam int IOMEM_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RSP  = 2'd2
   } iomem_state_t;

   localparam logic [IOMEM_DW-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

   // Top address byte of each peripheral region on the iomem bus.
   localparam logic [7:0] BASE_GPIO  = 8'h03;
   localparam logic [7:0] BASE_LOGIC = 8'h04;

   // The bus only carries word transfers, so the byte offset is dropped.
   function automatic logic [IOMEM_AW-1:0] word_align(input logic [IOMEM_AW-1:0] addr);
      return {addr[IOMEM_AW-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/iomem_watchdog.sv
// Ready-timeout watchdog: a down-counter that is reloaded while clear is high
// and counts down while enable is high. expired is raised during the
// TIMEOUT_CYCLES-th consecutive enabled cycle. A zero TIMEOUT_CYCLES removes
// the counter entirely and the watchdog never fires.
module iomem_watchdog
   import iomem_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   generate
      if (TIMEOUT_CYCLES == 0) begin : g_off
         logic w_unused_wdog;
         assign w_unused_wdog = i_clk ^ i_rst ^ i_clear ^ i_enable;
         assign o_expired     = 1'b0;
      end else begin : g_on
         localparam int W = $clog2(TIMEOUT_CYCLES + 1);
         // Loaded with N-1 so the terminal value 0 is reached on the N-th cycle.
         localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

         logic [W-1:0] r_remain;

         // Reload while disarmed, count down while the bus request is pending.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_remain <= '0;
            end else if (i_clear) begin
               r_remain <= LOAD;
            end else if (i_enable && (r_remain != '0)) begin
               r_remain <= r_remain - 1'b1;
            end
         end

         assign o_expired = i_enable && (r_remain == '0);
      end
   endgenerate

endmodule

// File: rtl/iomem_initiator.sv
// iomem bus master: accepts word-burst commands, issues one iomem transfer
// per beat at incrementing word addresses and returns one response per beat.
// A watchdog aborts the burst if the responder never raises ready.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// REQ   | iomem_valid high, waiting for the responder's ready pulse
// RSP   | bus idle, response held until rsp_ready
module iomem_initiator
   import iomem_pkg::*;
#(
   parameter int                   TIMEOUT_CYCLES = 1024,
   parameter logic [IOMEM_DW-1:0]  ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic                 i_clk,
   input  logic                 i_reset,

   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [IOMEM_AW-1:0]  i_cmd_addr,
   input  logic [IOMEM_DW-1:0]  i_cmd_wdata,
   input  logic [3:0]           i_cmd_wstrb,
   input  logic [7:0]           i_cmd_len,

   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [IOMEM_DW-1:0]  o_rsp_rdata,
   output logic                 o_rsp_err,
   output logic                 o_rsp_last,

   output logic                 o_busy,

   output logic                 o_iomem_valid,
   input  logic                 i_iomem_ready,
   output logic [IOMEM_AW-1:0]  o_iomem_addr,
   output logic [IOMEM_DW-1:0]  o_iomem_wdata,
   output logic [3:0]           o_iomem_wstrb,
   input  logic [IOMEM_DW-1:0]  i_iomem_rdata
);

   iomem_state_t          r_state;
   iomem_state_t          w_state_nxt;

   logic [IOMEM_AW-1:0]   r_addr;
   logic [IOMEM_DW-1:0]   r_wdata;
   logic [3:0]            r_wstrb;
   logic [7:0]            r_len;
   logic [7:0]            r_beat;
   logic                  r_iomem_valid;
   logic                  r_rsp_valid;
   logic [IOMEM_DW-1:0]   r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  r_rsp_last;
   logic                  r_cmd_ready;
   logic                  r_busy;

   logic [IOMEM_AW-1:0]   w_addr;
   logic [IOMEM_DW-1:0]   w_wdata;
   logic [3:0]            w_wstrb;
   logic [7:0]            w_len;
   logic [7:0]            w_beat;
   logic                  w_iomem_valid;
   logic                  w_rsp_valid;
   logic [IOMEM_DW-1:0]   w_rsp_rdata;
   logic                  w_rsp_err;
   logic                  w_rsp_last;
   logic                  w_cmd_ready;
   logic                  w_busy;

   logic                  w_cmd_fire;
   logic                  w_rsp_fire;
   logic                  w_expired;
   logic                  w_wdog_clear;
   logic                  w_wdog_enable;

   assign w_cmd_fire    = i_cmd_valid && r_cmd_ready;
   assign w_rsp_fire    = r_rsp_valid && i_rsp_ready;
   assign w_wdog_enable = (r_state == ST_REQ);
   assign w_wdog_clear  = (r_state != ST_REQ);

   iomem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .i_clk     (i_clk),
      .i_rst     (i_reset),
      .i_clear   (w_wdog_clear),
      .i_enable  (w_wdog_enable),
      .o_expired (w_expired)
   );

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; a ready pulse beats a coincident timeout.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_fire) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (i_iomem_ready || w_expired) begin
               w_state_nxt = ST_RSP;
            end
         end
         ST_RSP: begin
            if (w_rsp_fire) begin
               w_state_nxt = r_rsp_last ? ST_IDLE : ST_REQ;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Next values of every registered output and of the burst bookkeeping.
   always_comb begin
      w_addr        = r_addr;
      w_wdata       = r_wdata;
      w_wstrb       = r_wstrb;
      w_len         = r_len;
      w_beat        = r_beat;
      w_rsp_valid   = r_rsp_valid;
      w_rsp_rdata   = r_rsp_rdata;
      w_rsp_err     = r_rsp_err;
      w_rsp_last    = r_rsp_last;
      // Bus request and handshake flags follow the state being entered, so
      // iomem_valid is low for the whole RSP state and between bursts.
      w_iomem_valid = (w_state_nxt == ST_REQ);
      w_cmd_ready   = (w_state_nxt == ST_IDLE);
      w_busy        = (w_state_nxt != ST_IDLE);
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_fire) begin
               w_addr  = word_align(i_cmd_addr);
               w_wdata = i_cmd_wdata;
               w_wstrb = i_cmd_wstrb;
               w_len   = i_cmd_len;
               w_beat  = 8'd0;
            end
         end
         ST_REQ: begin
            if (i_iomem_ready) begin
               w_rsp_valid = 1'b1;
               w_rsp_rdata = (r_wstrb != 4'd0) ? '0 : i_iomem_rdata;
               w_rsp_err   = 1'b0;
               w_rsp_last  = (r_beat == r_len);
            end else if (w_expired) begin
               // Abandon the rest of the burst and flag this beat as final.
               w_rsp_valid = 1'b1;
               w_rsp_rdata = ERR_RDATA;
               w_rsp_err   = 1'b1;
               w_rsp_last  = 1'b1;
            end
         end
         ST_RSP: begin
            if (w_rsp_fire) begin
               w_rsp_valid = 1'b0;
               if (!r_rsp_last) begin
                  w_addr = r_addr + 32'd4;
                  w_beat = r_beat + 8'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_addr        <= '0;
         r_wdata       <= '0;
         r_wstrb       <= '0;
         r_len         <= '0;
         r_beat        <= '0;
         r_iomem_valid <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_last    <= 1'b0;
         r_cmd_ready   <= 1'b1;
         r_busy        <= 1'b0;
      end else begin
         r_addr        <= w_addr;
         r_wdata       <= w_wdata;
         r_wstrb       <= w_wstrb;
         r_len         <= w_len;
         r_beat        <= w_beat;
         r_iomem_valid <= w_iomem_valid;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_rdata   <= w_rsp_rdata;
         r_rsp_err     <= w_rsp_err;
         r_rsp_last    <= w_rsp_last;
         r_cmd_ready   <= w_cmd_ready;
         r_busy        <= w_busy;
      end
   end

   assign o_cmd_ready   = r_cmd_ready;
   assign o_busy        = r_busy;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_err     = r_rsp_err;
   assign o_rsp_last    = r_rsp_last;
   assign o_iomem_valid = r_iomem_valid;
   assign o_iomem_addr  = r_addr;
   assign o_iomem_wdata = r_wdata;
   assign o_iomem_wstrb = r_wstrb;

endmodule

// File: tb/tb_iomem_initiator.sv
// Bench for iomem_initiator: a behavioural responder and response consumer
// drive the DUT, and every beat is compared with what the command implies
// (word address sequence, fill data, read data from the responder, timeout).
module tb_iomem_initiator;

   localparam int          T   = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [7:0]  cmd_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_last;
   logic        busy;
   logic        io_valid;
   logic        io_ready;
   logic [31:0] io_addr;
   logic [31:0] io_wdata;
   logic [3:0]  io_wstrb;
   logic [31:0] io_rdata;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   iomem_initiator #(
      .TIMEOUT_CYCLES (T),
      .ERR_RDATA      (ERR)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_wdata   (cmd_wdata),
      .i_cmd_wstrb   (cmd_wstrb),
      .i_cmd_len     (cmd_len),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_rdata   (rsp_rdata),
      .o_rsp_err     (rsp_err),
      .o_rsp_last    (rsp_last),
      .o_busy        (busy),
      .o_iomem_valid (io_valid),
      .i_iomem_ready (io_ready),
      .o_iomem_addr  (io_addr),
      .o_iomem_wdata (io_wdata),
      .o_iomem_wstrb (io_wstrb),
      .i_iomem_rdata (io_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one command and play responder/consumer until its last response.
   // Per beat the responder raises ready on the w-th valid cycle (w in
   // [wlo,whi]; w > T never readies) and returns addr^salt; the consumer
   // stalls rsp_ready for a random count in [slo,shi].
   task automatic run_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic [7:0] len, input int wlo, input int whi,
                          input int slo, input int shi, input logic [31:0] salt);
      logic [31:0] base, ea, erd;
      int          i, vc, w, st, cyc, budget, overlap, hold_bad;
      bit          done, seen, exp_rsp, exp_req, erl, eerr, to;
      base = {a[31:2], 2'b00};
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_busy", busy, 0);
      cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws; cmd_len = len;
      rsp_ready = 1'b0; io_ready = 1'b0;
      step();
      cmd_valid = 1'b0;
      chk("accept_iomem_valid", io_valid, 1);
      chk("accept_cmd_ready", cmd_ready, 0);
      chk("accept_busy", busy, 1);
      i = 0; vc = 0; st = 0; w = $urandom_range(whi, wlo); seen = 0; done = 0; cyc = 0;
      overlap = 0; hold_bad = 0; exp_rsp = 0; exp_req = 0; erd = '0; erl = 0; eerr = 0; to = 0;
      budget = (int'(len) + 1) * (T + shi + 6) + 20;
      while (!done && cyc < budget) begin
         ea = base + 32'(i * 4);
         if (exp_rsp) begin
            chk("rsp_latency", {30'd0, rsp_valid, io_valid}, 32'd2);
            exp_rsp = 0;
         end
         if (exp_req) begin
            chk("next_req_latency", {30'd0, io_valid, rsp_valid}, 32'd2);
            exp_req = 0;
         end
         if (io_valid && rsp_valid) overlap++;
         if (io_valid) begin
            if (vc == 0) begin
               chk("beat_addr", io_addr, ea);
               chk("beat_wdata", io_wdata, wd);
               chk("beat_wstrb", {28'd0, io_wstrb}, {28'd0, ws});
            end else if (io_addr !== ea || io_wdata !== wd || io_wstrb !== ws) begin
               hold_bad++;
            end
            vc++;
            io_ready = (vc == w);
            io_rdata = (vc == w) ? (ea ^ salt) : $urandom;
            if (vc == w || vc == T) exp_rsp = 1;
         end else begin
            // Stray ready pulses while no request is pending must be ignored.
            io_ready = 1'($urandom_range(1, 0));
            io_rdata = $urandom;
         end
         if (rsp_valid) begin
            if (!seen) begin
               to   = (w > T);
               erd  = to ? ERR : ((ws != 4'd0) ? 32'd0 : (ea ^ salt));
               erl  = to || (i == int'(len));
               eerr = to;
               chk("rsp_rdata", rsp_rdata, erd);
               chk("rsp_err", rsp_err, eerr);
               chk("rsp_last", rsp_last, erl);
               chk("beat_valid_cycles", vc, to ? T : w);
               seen = 1;
               st = $urandom_range(shi, slo);
            end else if (rsp_rdata !== erd || rsp_err !== eerr || rsp_last !== erl) begin
               hold_bad++;
            end
            if (st > 0) begin
               rsp_ready = 1'b0;
               st--;
            end else begin
               rsp_ready = 1'b1;
               if (erl) done = 1;
               else begin
                  i++; vc = 0; seen = 0; exp_req = 1;
                  w = $urandom_range(whi, wlo);
               end
            end
         end else begin
            rsp_ready = 1'($urandom_range(1, 0));
         end
         // Commands offered while busy must not be taken.
         cmd_valid = 1'($urandom_range(1, 0));
         cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_len = 8'($urandom);
         step();
         cyc++;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0; io_ready = 1'b0;
      chk("cmd_done_in_budget", done, 1);
      chk("no_bus_during_rsp", overlap, 0);
      chk("held_stable", hold_bad, 0);
      chk("end_rsp_valid", rsp_valid, 0);
      chk("end_cmd_ready", cmd_ready, 1);
      chk("end_busy", busy, 0);
      chk("end_iomem_valid", io_valid, 0);
   endtask

   initial begin
      logic [3:0] ws;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; cmd_len = '0;
      rsp_ready = 1'b0; io_ready = 1'b0; io_rdata = '0;
      #1;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_iomem_valid", io_valid, 0);
      chk("rst_iomem_addr", io_addr, 0);
      chk("rst_iomem_wdata", io_wdata, 0);
      chk("rst_iomem_wstrb", {28'd0, io_wstrb}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_last", rsp_last, 0);
      step(); step();
      rst = 1'b0;
      step();

      // Single write, zero-wait responder.
      run_cmd(32'h0300_0001, 32'h0000_00A5, 4'hF, 8'd0, 1, 1, 0, 0, 32'h55);
      // Read burst of four, data = addr ^ 0x55.
      run_cmd(32'h0400_0000, 32'h0, 4'h0, 8'd3, 1, 1, 0, 0, 32'h55);
      // Response backpressure of 10 cycles per beat.
      run_cmd(32'h0400_0100, 32'h0, 4'h0, 8'd1, 1, 2, 10, 10, 32'h55);
      // Dead responder: first beat times out, remaining beats abandoned.
      run_cmd(32'h0300_0010, 32'h1234_5678, 4'hF, 8'd2, 100, 100, 0, 0, 32'h0);
      // Ready arrives in the same cycle the timeout would fire.
      run_cmd(32'h0400_0020, 32'h0, 4'h0, 8'd0, T, T, 0, 2, 32'h55);
      // Maximum-length burst.
      run_cmd(32'h0400_8000, 32'h0, 4'h0, 8'd255, 1, 2, 0, 1, $urandom);

      for (int n = 0; n < 25; n++) begin
         ws = ($urandom_range(1, 0) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
         run_cmd($urandom, $urandom, ws, 8'($urandom_range(6, 0)), 1, 10, 0, 3, $urandom);
      end

      // Address wrap, then reset while the second beat is pending.
      chk("wrap_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_addr = 32'hFFFF_FFFC; cmd_wdata = 32'hCAFE_0001; cmd_wstrb = 4'hF;
      cmd_len = 8'd1;
      step();
      cmd_valid = 1'b0;
      chk("wrap_beat0_addr", io_addr, 32'hFFFF_FFFC);
      io_ready = 1'b1;
      step();
      io_ready = 1'b0;
      chk("wrap_beat0_rsp", rsp_valid, 1);
      chk("wrap_beat0_last", rsp_last, 0);
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("wrap_beat1_valid", io_valid, 1);
      chk("wrap_beat1_addr", io_addr, 32'h0000_0000);
      step();
      #2 rst = 1'b1;
      #1;
      chk("rst_async_iomem_valid", io_valid, 0);
      chk("rst_async_busy", busy, 0);
      step(); step();
      rst = 1'b0;
      step();
      chk("post_rst_rsp_valid", rsp_valid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_iomem_valid", io_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
